// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register.
// Performs aligned word loads/stores on an internal data memory, registers the
// write-back value and tracks misaligned accesses (sticky flag + saturating count).
module mem_wb_stage #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCnew_EX,
    input  logic [31:0] out_EX,
    input  logic [31:0] busB_EX,
    input  logic [4:0]  RW_EX,
    input  logic        MemWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        RegWrite_EX,
    output logic [31:0] busW_MEM,
    output logic [4:0]  RW_MEM,
    output logic        RegWrite_MEM,
    output logic [31:0] PCnew_MEM,
    output logic        misalign_err,
    output logic [7:0]  err_count
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WORD_W-1:0]     mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  aligned;
    logic                  misalign;
    logic                  store_en;
    logic                  regwrite_nxt;
    logic [WORD_W-1:0]     load_data;
    logic [WORD_W-1:0]     wb_data;
    logic                  unused_addr_bits;

    // Address decode, load read, write-back select and error detection
    always_comb begin
        idx              = out_EX[DEPTH_LOG2+1:2];
        aligned          = (out_EX[1:0] == 2'b00);
        misalign         = (MemWrite_EX | MemtoReg_EX) & ~aligned;
        store_en         = MemWrite_EX & aligned & ~rst;
        load_data        = '0;
        if (aligned) begin
            load_data    = mem[idx];
        end
        wb_data          = MemtoReg_EX ? load_data : out_EX;
        // A misaligned load must not write garbage to the register file
        regwrite_nxt     = RegWrite_EX & ~(MemtoReg_EX & ~aligned);
        // Upper address bits wrap and are intentionally ignored
        unused_addr_bits = ^out_EX[31:DEPTH_LOG2+2];
    end

    // Data memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[idx] <= busB_EX;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            busW_MEM     <= '0;
            RW_MEM       <= '0;
            RegWrite_MEM <= 1'b0;
            PCnew_MEM    <= '0;
        end else begin
            busW_MEM     <= wb_data;
            RW_MEM       <= RW_EX;
            RegWrite_MEM <= regwrite_nxt;
            PCnew_MEM    <= PCnew_EX;
        end
    end

    // Sticky misalignment flag and saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
            err_count    <= '0;
        end else if (misalign) begin
            misalign_err <= 1'b1;
            if (err_count != CNT_MAX) begin
                err_count <= CNT_W'(err_count + CNT_W'(1));
            end
        end
    end

endmodule
